// File: rtl/store_buffer_bridge.sv
// Store buffer bridge between the core MEM stage and a valid/ready memory bus.
// Stores are posted into a FIFO, loads forward from it or go out as blocking bus reads.
module store_buffer_bridge #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        core_mem_write,
    input  logic        core_mem_read,
    input  logic [31:0] core_mem_addr,
    input  logic [31:0] core_mem_wdata,
    output logic [31:0] core_mem_rdata,
    output logic        core_stall,
    output logic        sb_empty,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_req_we,
    output logic [31:0] bus_req_addr,
    output logic [31:0] bus_req_wdata,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rsp_rdata
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned AW = 30;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_REQ  = 2'd1,
        S_RD_WAIT = 2'd2,
        S_RD_DONE = 2'd3
    } state_t;

    logic [AW-1:0] r_addr [DEPTH];
    logic [31:0]   r_data [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [31:0]   r_rdata_q;
    state_t        r_state;

    state_t        w_state_nxt;
    logic          w_full;
    logic          w_empty;
    logic          w_hit;
    logic [31:0]   w_fwd_data;
    logic          w_load;
    logic          w_miss;
    logic          w_push;
    logic          w_pop;
    logic          w_capture;
    logic          w_unused;

    assign w_unused = ^core_mem_addr[1:0];

    assign w_full   = (r_count == CW'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign sb_empty = w_empty;

    // Youngest-match forwarding: later (younger) entries overwrite older hits.
    always_comb begin
        w_hit      = 1'b0;
        w_fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((CW'(k) < r_count) &&
                (r_addr[r_rd_ptr + PW'(k)] == core_mem_addr[31:2])) begin
                w_hit      = 1'b1;
                w_fwd_data = r_data[r_rd_ptr + PW'(k)];
            end
        end
    end

    // A simultaneous write+read is treated as a write.
    assign w_load = core_mem_read & ~core_mem_write;
    assign w_miss = w_load & ~w_hit;

    assign core_mem_rdata = (w_load && w_hit) ? w_fwd_data : r_rdata_q;

    // Load-miss FSM plus drain/push control.
    always_comb begin
        w_state_nxt   = r_state;
        core_stall    = 1'b0;
        bus_req_valid = 1'b0;
        bus_req_we    = 1'b0;
        bus_req_addr  = '0;
        bus_req_wdata = '0;
        w_push        = 1'b0;
        w_pop         = 1'b0;
        w_capture     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (core_mem_write) begin
                    if (w_full) core_stall = 1'b1;
                    else        w_push     = 1'b1;
                end else if (w_miss) begin
                    core_stall  = 1'b1;
                    w_state_nxt = S_RD_REQ;
                end
                // A pending miss takes the bus ahead of queued stores.
                if (!w_empty && !w_miss) begin
                    bus_req_valid = 1'b1;
                    bus_req_we    = 1'b1;
                    bus_req_addr  = {r_addr[r_rd_ptr], 2'b00};
                    bus_req_wdata = r_data[r_rd_ptr];
                    w_pop         = bus_req_ready;
                end
            end
            S_RD_REQ: begin
                core_stall    = 1'b1;
                bus_req_valid = 1'b1;
                bus_req_addr  = {core_mem_addr[31:2], 2'b00};
                if (bus_req_ready) w_state_nxt = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                core_stall = 1'b1;
                if (bus_rsp_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_RD_DONE;
                end
            end
            S_RD_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state   <= S_IDLE;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_rdata_q <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_push && w_pop) r_count <= r_count - CW'(1);
            if (w_capture) r_rdata_q <= bus_rsp_rdata;
        end
    end

    // Entry storage needs no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wr_ptr] <= core_mem_addr[31:2];
            r_data[r_wr_ptr] <= core_mem_wdata;
        end
    end

endmodule
